// File: rtl/mem_fifo_ctrl_if.sv
// rtl/mem_fifo_ctrl_if.sv - push/pop handshake and mem-side bus of the FIFO controller
// Optional overflow/underflow flags exist only when MEM_FIFO_ERR_EN is defined.
interface mem_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q;
`ifdef MEM_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport slave (
    input  push, push_data, pop, mem_q,
    output pop_data, pop_valid, full, empty, count,
           mem_data, mem_write_addr, mem_read_addr, mem_we
`ifdef MEM_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );

  modport master (
    output push, push_data, pop, mem_q,
    input  pop_data, pop_valid, full, empty, count,
           mem_data, mem_write_addr, mem_read_addr, mem_we
`ifdef MEM_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller wrapping a dual-port mem with registered read data
// Define MEM_FIFO_ERR_EN to add sticky overflow/underflow flags.
module mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_fifo_ctrl_if.slave   bus
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  full, empty;
  logic                  push_acc, pop_acc;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push_acc = bus.push & ~full;
  assign pop_acc  = bus.pop & ~empty;

  always_comb begin
    wr_ptr_d    = push_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = pop_acc  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    pop_valid_d = pop_acc;
    count_d     = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  // mem registers q from read_addr, so data lines up with the delayed pop_valid
  assign bus.pop_data       = bus.mem_q;
  assign bus.pop_valid      = pop_valid_q;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.count          = count_q;
  assign bus.mem_data       = bus.push_data;
  assign bus.mem_write_addr = wr_ptr_q;
  assign bus.mem_read_addr  = rd_ptr_q;
  assign bus.mem_we         = push_acc;

`ifdef MEM_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.push & full);
    underflow_d = underflow_q | (bus.pop & empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - scoreboard bench for mem_fifo_ctrl with a behavioural mem
module tb_mem_fifo_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_fifo_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

  mem_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [15:0] mem_arr [64];
  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_write_addr] <= bus.mem_data;
    bus.mem_q <= mem_arr[bus.mem_read_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] sb [$];
  int exp_pops = 0;
  int seen_pops = 0;
  int m_cnt = 0;
  logic [5:0] m_wr = '0;
  logic [5:0] m_rd = '0;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.pop_valid === 1'b1) begin
      seen_pops++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_data: unexpected pop_valid with data 0x%0h at %0t", bus.pop_data, $time);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (bus.pop_data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", bus.pop_data, e, $time);
        end
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic p, input logic [15:0] d, input logic o);
    logic pacc, oacc;
    bus.push = p;
    bus.push_data = d;
    bus.pop = o;
    pacc = p && (m_cnt < 64);
    oacc = o && (m_cnt > 0);
    if (p && m_cnt == 64) m_ovf = 1'b1;
    if (o && m_cnt == 0) m_unf = 1'b1;
    #1;
    chk("mem_we", 32'(bus.mem_we), 32'(pacc));
    chk("mem_write_addr", 32'(bus.mem_write_addr), 32'(m_wr));
    chk("mem_read_addr", 32'(bus.mem_read_addr), 32'(m_rd));
    if (pacc) begin
      chk("mem_data", 32'(bus.mem_data), 32'(d));
      sb.push_back(d);
    end
    @(posedge clk);
    if (pacc) m_wr = m_wr + 6'd1;
    if (oacc) begin
      m_rd = m_rd + 6'd1;
      exp_pops++;
    end
    m_cnt = m_cnt + int'(pacc) - int'(oacc);
    #1;
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("full", 32'(bus.full), 32'(m_cnt == 64));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("pop_valid", 32'(bus.pop_valid), 32'(oacc));
`ifdef MEM_FIFO_ERR_EN
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
    bus.push = 1'b0;
    bus.pop = 1'b0;
  endtask

  task automatic idle_and_sync(input string tag);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk({tag, "_pop_count"}, 32'(seen_pops), 32'(exp_pops));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    bus.push = 1'b0;
    bus.push_data = '0;
    bus.pop = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);

    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    step(1'b1, 16'h3333, 1'b0);
    drain(3);
    idle_and_sync("order");

    for (int i = 0; i < 64; i++) step(1'b1, 16'(i), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    step(1'b1, 16'hDEAD, 1'b0);
    chk("fill_count", 32'(bus.count), 32'd64);
    drain(64);
    idle_and_sync("fill");

    // pointers start at 3 here, so 80 entries cross the 63 -> 0 boundary
    for (int i = 0; i < 40; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
    drain(40);
    for (int i = 0; i < 40; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0);
    drain(40);
    idle_and_sync("wrap");

    for (int i = 0; i < 5; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0);
    step(1'b1, 16'hA005, 1'b1);
    chk("simul5_count", 32'(bus.count), 32'd5);
    drain(5);
    idle_and_sync("simul5");

    step(1'b1, 16'hB000, 1'b1);
    chk("simul0_count", 32'(bus.count), 32'd1);
    for (int i = 1; i < 64; i++) step(1'b1, 16'hB000 + 16'(i), 1'b0);
    step(1'b1, 16'hBEEF, 1'b1);
    chk("simul64_count", 32'(bus.count), 32'd63);
    drain(63);
    idle_and_sync("simul64");

    step(1'b1, 16'hC001, 1'b0);
    step(1'b1, 16'hC002, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("midpop_valid_before", 32'(bus.pop_valid), 32'd1);
    reset_n = 1'b0;
    sb.delete();
    exp_pops = seen_pops;
    m_cnt = 0;
    m_wr = '0;
    m_rd = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    chk("midpop_valid", 32'(bus.pop_valid), 32'd0);
    chk("midpop_count", 32'(bus.count), 32'd0);
    chk("midpop_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 16'h0, 1'b1);
    idle_and_sync("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_fifo_ctrl.md
Name: mem_fifo_ctrl

Overview:
- FIFO controller placed directly upstream of the dual-port `mem` block (DATA_WIDTH=16, ADDR_WIDTH=6).
- Turns `mem` into a 2^ADDR_WIDTH-entry FIFO by driving its data, write_addr, read_addr and we, and by returning its q as pop data.
- Owns the read/write pointers, occupancy count, full/empty flags and the push/pop handshake.
- Producers and consumers (e.g. an I/O buffer stage) talk only to this block, never to `mem` directly.

Parameters:
DATA_WIDTH, 16, width of one entry; must match the attached mem.
ADDR_WIDTH, 6, mem address width; FIFO depth = 2^ADDR_WIDTH (64).

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
push  input  1  write request
push_data  input  DATA_WIDTH  entry to write
pop  input  1  read request
pop_data  output  DATA_WIDTH  popped entry, valid when pop_valid=1
pop_valid  output  1  one-cycle strobe, pop_data valid
full  output  1  count == 2^ADDR_WIDTH
empty  output  1  count == 0
count  output  ADDR_WIDTH+1  current occupancy
mem_data  output  DATA_WIDTH  to mem.data
mem_write_addr  output  ADDR_WIDTH  to mem.write_addr
mem_read_addr  output  ADDR_WIDTH  to mem.read_addr
mem_we  output  1  to mem.we
mem_q  input  DATA_WIDTH  from mem.q

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Assumed mem contract: write on the clk edge when we=1; q is registered from read_addr, so it is valid one cycle after the address is presented.
- Reset (asynchronous, reset_n=0):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, pop_valid=0.
  - Mid-operation reset discards all contents and any pop in flight; pop_valid is forced to 0 immediately.
- Push acceptance: push_acc = push & ~full.
  - mem_we = push_acc (combinational).
  - mem_data = push_data.
  - mem_write_addr = wr_ptr.
  - On the edge: wr_ptr += 1, wrapping modulo 2^ADDR_WIDTH.
- Pop acceptance: pop_acc = pop & ~empty.
  - mem_read_addr = rd_ptr (combinational).
  - On the edge: rd_ptr += 1 (wraps), and the registered pop_valid is set to 1 for exactly one cycle.
  - pop_data = mem_q (pass-through). Pop latency is 1 cycle: pop_data and pop_valid appear in the cycle after acceptance.
- Count and flags:
  - count += push_acc - pop_acc each edge; push_acc and pop_acc together leave count unchanged.
  - full and empty are decoded from the registered count.
- Full boundary: push while full is ignored (no mem write, no state change), even if pop is asserted in the same cycle. The pop is still accepted, so count goes 64 -> 63.
- Empty boundary: pop while empty is ignored (pop_valid stays 0), even if push is asserted in the same cycle. The push is still accepted, so count goes 0 -> 1.
- No read-during-write hazard: only entries written on an earlier edge are ever read.
- Back-to-back pops produce one pop_valid per cycle with consecutive entries.
- Pointers are ADDR_WIDTH bits wide; count carries the extra bit needed to distinguish full from empty.

Optional Feature:
- Macro: MEM_FIFO_ERR_EN.
- When defined, two outputs are added: overflow and underflow, each 1 bit and sticky.
  - overflow is set by push & full.
  - underflow is set by pop & empty.
  - Both are cleared only by reset_n=0; their reset value is 0.
- When undefined, neither port exists and rejected requests are silently dropped.

Test Plan:
- Reset check: after reset_n is released -> count=0, empty=1, full=0, pop_valid=0, mem_we=0.
- Ordering: push 0x1111, 0x2222, 0x3333, then 3 consecutive pops -> pop_valid high on 3 consecutive cycles, starting 1 cycle after the first pop, carrying 0x1111, 0x2222, 0x3333 in order; empty=1 at the end.
- Fill to full: push 64 entries (value = index) -> full=1, count=64. A 65th push with value 0xDEAD -> mem_we=0 and count stays 64 (overflow=1 with MEM_FIFO_ERR_EN). Draining returns 0..63.
- Wrap-around: push 40, pop 40, push 40, pop 40 -> all 80 values return in order. Pointers wrap past 63 to 0; mem_write_addr reads 63 then 0 at the crossing.
- Simultaneous push and pop:
  - At count=5 -> count stays 5 and the oldest entry is returned.
  - At count=0 with push=pop=1 -> only the push is taken, count=1, no pop_valid.
  - At count=64 with push=pop=1 -> only the pop is taken, count=63.
- Reset mid-pop: pop accepted, then reset_n=0 before the next edge -> pop_valid=0 immediately, count=0, empty=1. A subsequent pop is ignored (underflow=1 with MEM_FIFO_ERR_EN).
